// File: rtl/sign_extend.sv
// LEGv8 immediate generator: field extract + sign/zero extend, registered.
// Ports: clk, rst_n, en, inst, imm_op (one-hot B/CB/I/shift/D), immediate, imm_valid.
module sign_extend #(
  parameter int INST_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [INST_W-1:0] inst,
  input  logic [4:0]        imm_op,
  output logic [DATA_W-1:0] immediate,
  output logic              imm_valid
);

  localparam logic [4:0] OP_B  = 5'b10000;
  localparam logic [4:0] OP_CB = 5'b01000;
  localparam logic [4:0] OP_I  = 5'b00100;
  localparam logic [4:0] OP_SH = 5'b00010;
  localparam logic [4:0] OP_D  = 5'b00001;

  logic signed [25:0] b_f;
  logic signed [18:0] cb_f;
  logic        [11:0] i_f;
  logic        [5:0]  sh_f;
  logic signed [8:0]  d_f;

  logic [DATA_W-1:0] imm_b;
  logic [DATA_W-1:0] imm_cb;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_sh;
  logic [DATA_W-1:0] imm_d;

  logic [DATA_W-1:0] imm_nxt;
  logic              vld_nxt;

  // Each format only ever touches its own field slice, so
  // unselected instruction bits cannot leak into the result.
  assign b_f  = inst[25:0];
  assign cb_f = inst[23:5];
  assign i_f  = inst[21:10];
  assign sh_f = inst[15:10];
  assign d_f  = inst[20:12];

  // Signed fields widen with sign fill, unsigned with zeros.
  assign imm_b  = DATA_W'(b_f);
  assign imm_cb = DATA_W'(cb_f);
  assign imm_i  = DATA_W'(i_f);
  assign imm_sh = DATA_W'(sh_f);
  assign imm_d  = DATA_W'(d_f);

  // Exact-match select: multi-hot codes fall to zero, not
  // to whichever bit would win a priority chain.
  always_comb begin
    imm_nxt = '0;
    vld_nxt = 1'b0;
    case (imm_op)
      OP_B: begin
        imm_nxt = imm_b;
        vld_nxt = 1'b1;
      end
      OP_CB: begin
        imm_nxt = imm_cb;
        vld_nxt = 1'b1;
      end
      OP_I: begin
        imm_nxt = imm_i;
        vld_nxt = 1'b1;
      end
      OP_SH: begin
        imm_nxt = imm_sh;
        vld_nxt = 1'b1;
      end
      OP_D: begin
        imm_nxt = imm_d;
        vld_nxt = 1'b1;
      end
      default: begin
        imm_nxt = '0;
        vld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      immediate <= '0;
      imm_valid <= 1'b0;
    end else if (en) begin
      immediate <= imm_nxt;
      imm_valid <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_sign_extend.sv
// Self-checking bench for sign_extend: directed table, reset/enable
// sequences, and randomized checks against an arithmetic reference model.
module tb_sign_extend;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] inst = '0;
  logic [4:0]  imm_op = '0;
  logic [63:0] immediate;
  logic        imm_valid;

  int checks = 0;
  int errors = 0;

  sign_extend #(.INST_W(32), .DATA_W(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .inst(inst),
    .imm_op(imm_op),
    .immediate(immediate),
    .imm_valid(imm_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] fld;
    logic [63:0] exp_imm;
    logic        exp_v;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp,
                       input logic gv,
                       input logic ev);
    checks++;
    if (got !== exp || gv !== ev) begin
      errors++;
      $display("FAIL %s: got imm=%h valid=%b, expected imm=%h valid=%b",
               name, got, gv, exp, ev);
    end
  endtask

  function automatic logic [31:0] field_mask(input logic [4:0] op);
    case (op)
      5'b10000: return 32'h03FF_FFFF;
      5'b01000: return 32'h00FF_FFE0;
      5'b00100: return 32'h003F_FC00;
      5'b00010: return 32'h0000_FC00;
      5'b00001: return 32'h001F_F000;
      default:  return 32'h0;
    endcase
  endfunction

  // Reference: pick field position/width, extract arithmetically,
  // subtract 2^w when signed and the top field bit is set.
  task automatic ref_model(input logic [31:0] i,
                           input logic [4:0] op,
                           output logic [63:0] r,
                           output logic v);
    int lo;
    int w;
    bit sx;
    longint val;
    longint one;
    one = 1;
    v = 1'b1;
    lo = 0;
    w = 1;
    sx = 0;
    case (op)
      5'b10000: begin lo = 0;  w = 26; sx = 1; end
      5'b01000: begin lo = 5;  w = 19; sx = 1; end
      5'b00100: begin lo = 10; w = 12; sx = 0; end
      5'b00010: begin lo = 10; w = 6;  sx = 0; end
      5'b00001: begin lo = 12; w = 9;  sx = 1; end
      default:  v = 1'b0;
    endcase
    if (!v) begin
      r = '0;
    end else begin
      val = longint'({32'h0, i}) >> lo;
      val = val % (one << w);
      if (sx && val >= (one << (w - 1)))
        val = val - (one << w);
      r = 64'(val);
    end
  endtask

  task automatic drive(input logic [4:0] op,
                       input logic [31:0] fv,
                       input bit xfill);
    logic [31:0] m;
    logic [31:0] filler;
    m = field_mask(op);
    filler = xfill ? 32'hxxxx_xxxx : 32'hFFFF_FFFF;
    imm_op = op;
    inst = (fv & m) | (~m & filler);
  endtask

  initial begin
    logic [63:0] mexp;
    logic        mv;
    logic [63:0] held;
    logic        held_v;

    vecs[0] = '{"B_neg",   5'b10000, 32'h0200_0001,
                64'hFFFF_FFFF_FE00_0001, 1'b1};
    vecs[1] = '{"B_pos",   5'b10000, 32'h0000_0001,
                64'h0000_0000_0000_0001, 1'b1};
    vecs[2] = '{"CB_neg",  5'b01000, 32'h0080_0020,
                64'hFFFF_FFFF_FFFC_0001, 1'b1};
    vecs[3] = '{"I_zext",  5'b00100, 32'h0020_0400,
                64'h0000_0000_0000_0801, 1'b1};
    vecs[4] = '{"SHAMT",   5'b00010, 32'h0000_8400,
                64'h0000_0000_0000_0021, 1'b1};
    vecs[5] = '{"D_neg",   5'b00001, 32'h0010_1000,
                64'hFFFF_FFFF_FFFF_FF01, 1'b1};
    vecs[6] = '{"D_pos",   5'b00001, 32'h0000_1000,
                64'h0000_0000_0000_0001, 1'b1};
    vecs[7] = '{"NONE",    5'b00000, 32'h0000_0000,
                64'h0, 1'b0};
    vecs[8] = '{"INV_B_D", 5'b10001, 32'h0000_0000,
                64'h0, 1'b0};
    vecs[9] = '{"INV_ALL", 5'b11111, 32'h0000_0000,
                64'h0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1 check("reset_state", immediate, 64'h0, imm_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;

    // Directed table, X fill then ones fill on non-field bits
    foreach (vecs[k]) begin
      for (int f = 0; f < 2; f++) begin
        @(negedge clk);
        drive(vecs[k].op, vecs[k].fld, f == 0);
        @(posedge clk);
        #1 check({vecs[k].name, f == 0 ? "_xfill" : "_1fill"},
                 immediate, vecs[k].exp_imm, imm_valid, vecs[k].exp_v);
      end
    end

    // Asynchronous reset mid-cycle after a nonzero load
    @(negedge clk);
    drive(5'b10000, 32'h0200_0001, 1'b0);
    @(posedge clk);
    #1 check("pre_reset_load", immediate,
             64'hFFFF_FFFF_FE00_0001, imm_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", immediate, 64'h0, imm_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Enable hold then re-enable
    @(negedge clk);
    drive(5'b00010, 32'h0000_8400, 1'b0);
    @(posedge clk);
    #1 check("en_load", immediate, 64'h21, imm_valid, 1'b1);
    @(negedge clk);
    en = 1'b0;
    drive(5'b10000, 32'h0200_0001, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 check("en_hold", immediate, 64'h21, imm_valid, 1'b1);
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 check("en_reload", immediate,
             64'hFFFF_FFFF_FE00_0001, imm_valid, 1'b1);

    // Randomized against the reference model
    held = immediate;
    held_v = imm_valid;
    held = 64'hFFFF_FFFF_FE00_0001;
    held_v = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        imm_op = 5'($urandom);
      else
        imm_op = 5'(1 << $urandom_range(0, 4));
      inst = $urandom;
      @(posedge clk);
      if (en) begin
        ref_model(inst, imm_op, mexp, mv);
        held = mexp;
        held_v = mv;
      end
      #1 check("random", immediate, held, imm_valid, held_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
